// File: rtl/dm_store_mem_if.sv
// dm_store_mem_if: MEM-stage data memory bus between pipeline and memory
interface dm_store_mem_if;
  logic [31:0] A;
  logic [31:0] WD;
  logic        MemWrite;
  logic        MemRead;
  logic [1:0]  StOp;
  logic [1:0]  LdOp;
  logic [31:0] RD;
  logic [3:0]  BE;
  logic        ExcAdES;
  logic        ExcAdEL;
  modport master (output A, WD, MemWrite, MemRead, StOp, LdOp, input RD, BE, ExcAdES, ExcAdEL);
  modport slave (input A, WD, MemWrite, MemRead, StOp, LdOp, output RD, BE, ExcAdES, ExcAdEL);
endinterface

// File: rtl/dm_store_mem.sv
// dm_store_mem: data memory with byte-lane stores, combinational word read and address-error flags
module dm_store_mem #(
  parameter int DEPTH = 3072,
  parameter int AW    = 12
) (
  input logic            clk,
  input logic            reset,
  dm_store_mem_if.slave  bus
);
  logic [31:0] mem_q [DEPTH];
  logic [31:0] wr_d;
  logic [31:0] lane_d;
  logic [3:0]  be_raw;
  logic [AW-1:0] idx;
  logic        oor, st_mis, ld_mis;
  // address checks, byte enables, lane replication and merged store word
  always_comb begin
    oor    = bus.A >= 32'(4 * DEPTH);
    idx    = oor ? '0 : bus.A[AW+1:2];
    st_mis = (bus.StOp == 2'b00) ? |bus.A[1:0] : (bus.StOp == 2'b01) ? bus.A[0] : 1'b0;
    ld_mis = (bus.LdOp == 2'b00) ? |bus.A[1:0] : (bus.LdOp == 2'b01) ? bus.A[0] : 1'b0;
    bus.ExcAdES = bus.MemWrite & (st_mis | oor);
    bus.ExcAdEL = bus.MemRead & (bus.LdOp != 2'b11) & (ld_mis | oor);
    be_raw = (bus.StOp == 2'b00) ? 4'b1111 :
             (bus.StOp == 2'b01) ? (bus.A[1] ? 4'b1100 : 4'b0011) :
             (bus.StOp == 2'b10) ? 4'b0001 << bus.A[1:0] : 4'b0000;
    bus.BE = (bus.MemWrite & ~bus.ExcAdES) ? be_raw : 4'b0000;
    lane_d = (bus.StOp == 2'b10) ? {4{bus.WD[7:0]}} :
             (bus.StOp == 2'b01) ? {2{bus.WD[15:0]}} : bus.WD;
    bus.RD = oor ? 32'h0 : mem_q[idx];
    wr_d   = mem_q[idx];
    for (int i = 0; i < 4; i++)
      wr_d[8*i +: 8] = bus.BE[i] ? lane_d[8*i +: 8] : mem_q[idx][8*i +: 8];
  end
  // reset clears every word; otherwise commit the merged word when any lane is enabled
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++)
        mem_q[i] <= 32'h0;
    end else if (|bus.BE) begin
      mem_q[idx] <= wr_d;
    end
  end
endmodule
